// File: rtl/game_pkg.sv
// Shared types and constants for the game screen sequencer.
// States, HID keycodes, sprite select codes and screen flag helpers.
package game_pkg;

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    END   = 3'd3,
    PAUSE = 3'd4
  } state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_P     = 8'h13;

  localparam logic [2:0] PKMN_CHARMANDER = 3'd1;
  localparam logic [2:0] PKMN_SQUIRTLE   = 3'd2;
  localparam logic [2:0] PKMN_PIPLUP     = 3'd3;

  localparam logic [3:0] BALL_0 = 4'b0001;
  localparam logic [3:0] BALL_1 = 4'b0010;
  localparam logic [3:0] BALL_2 = 4'b0100;
  localparam logic [3:0] BALL_3 = 4'b1000;

  typedef struct packed {
    logic menu;
    logic play;
    logic hit;
    logic fin;
  } flags_t;

  // PAUSE blanks every flag; illegal encodings show the menu.
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f = '0;
    case (s)
      MENU:    f.menu = 1'b1;
      PLAY:    f.play = 1'b1;
      HIT:     f.hit  = 1'b1;
      END:     f.fin  = 1'b1;
      PAUSE:   f      = '0;
      default: f.menu = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [2:0] pkmn_next(logic [2:0] p);
    return (p == PKMN_PIPLUP) ? PKMN_CHARMANDER : p + 3'd1;
  endfunction

  function automatic logic [2:0] pkmn_prev(logic [2:0] p);
    return (p == PKMN_CHARMANDER) ? PKMN_PIPLUP : p - 3'd1;
  endfunction

endpackage

// File: rtl/game_screen_ctrl_if.sv
// Bundle between keyboard/collision logic, the sequencer
// and the colour mapper.
interface game_screen_ctrl_if;
  logic       VGA_VS;
  logic [7:0] keycode;
  logic       hit;
  logic       goal_reached;
  logic       menu_screen;
  logic       H_STATE;
  logic       E_STATE;
  logic       play_active;
  logic [2:0] pokemon;
  logic [3:0] pokeball;
  logic [1:0] lives;
  logic [3:0] score_tens;
  logic [3:0] score_ones;

  modport master (
    input  VGA_VS, keycode, hit, goal_reached,
    output menu_screen, H_STATE, E_STATE,
    output play_active, pokemon, pokeball,
    output lives, score_tens, score_ones
  );

  modport slave (
    output VGA_VS, keycode, hit, goal_reached,
    input  menu_screen, H_STATE, E_STATE,
    input  play_active, pokemon, pokeball,
    input  lives, score_tens, score_ones
  );
endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score: increments, saturates at 99,
// synchronous clear.
module bcd_score_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic at_max;

  assign at_max = (tens == 4'd9) && (ones == 4'd9);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !at_max) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_screen_ctrl.sv
// MENU/PLAY/HIT/END sequencer driving the VGA colour mapper.
// Define GAME_PAUSE_EN to add a PAUSE state toggled by the P key.
module game_screen_ctrl #(
  parameter int HIT_FRAMES  = 60,
  parameter int START_LIVES = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  game_screen_ctrl_if.master  bus
);
  import game_pkg::*;

  localparam int CW = $clog2(HIT_FRAMES + 1);
  localparam logic [1:0]    LIVES0   = 2'(START_LIVES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HIT_FRAMES - 1);

  state_t        state;
  flags_t        flags;
  logic          vs_q;
  logic [7:0]    key_q;
  logic [CW-1:0] hit_cnt;
  logic [2:0]    pkmn;
  logic [3:0]    ball;
  logic [1:0]    lives_q;

  logic tick;
  logic key_evt;
  logic k_enter;
  logic k_right;
  logic k_left;
  logic k_down;
  logic k_up;
  logic score_clr;
  logic score_inc;

  assign tick    = vs_q & ~bus.VGA_VS;
  assign key_evt = (bus.keycode != 8'h00) &&
                   (bus.keycode != key_q);
  assign k_enter = key_evt && (bus.keycode == KEY_ENTER);
  assign k_right = key_evt && (bus.keycode == KEY_RIGHT);
  assign k_left  = key_evt && (bus.keycode == KEY_LEFT);
  assign k_down  = key_evt && (bus.keycode == KEY_DOWN);
  assign k_up    = key_evt && (bus.keycode == KEY_UP);

`ifdef GAME_PAUSE_EN
  logic k_p;
  assign k_p = key_evt && (bus.keycode == KEY_P);
`endif

  // Hit beats goal in the same cycle, so the score only moves on
  // a clean goal.
  assign score_clr = (state == MENU) && k_enter;
  assign score_inc = (state == PLAY) && bus.goal_reached &&
                     !bus.hit;

  bcd_score_counter u_score (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (score_clr),
    .inc  (score_inc),
    .tens (bus.score_tens),
    .ones (bus.score_ones)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= MENU;
      flags   <= flags_of(MENU);
      vs_q    <= 1'b0;
      key_q   <= 8'h00;
      hit_cnt <= '0;
      pkmn    <= PKMN_CHARMANDER;
      ball    <= BALL_0;
      lives_q <= LIVES0;
    end else begin
      vs_q  <= bus.VGA_VS;
      key_q <= bus.keycode;
      case (state)
        MENU: begin
          unique case (1'b1)
            k_right: pkmn <= pkmn_next(pkmn);
            k_left:  pkmn <= pkmn_prev(pkmn);
            k_down:  ball <= {ball[2:0], ball[3]};
            k_up:    ball <= {ball[0], ball[3:1]};
            k_enter: begin
              lives_q <= LIVES0;
              state   <= PLAY;
              flags   <= flags_of(PLAY);
            end
            default: ;
          endcase
        end
        PLAY: begin
          if (bus.hit) begin
            if (lives_q <= 2'd1) begin
              lives_q <= 2'd0;
              state   <= END;
              flags   <= flags_of(END);
            end else begin
              lives_q <= lives_q - 2'd1;
              hit_cnt <= '0;
              state   <= HIT;
              flags   <= flags_of(HIT);
            end
          end
`ifdef GAME_PAUSE_EN
          else if (k_p) begin
            state <= PAUSE;
            flags <= flags_of(PAUSE);
          end
`endif
        end
        HIT: begin
          if (tick) begin
            if (hit_cnt == CNT_LAST) begin
              state <= PLAY;
              flags <= flags_of(PLAY);
            end else begin
              hit_cnt <= hit_cnt + 1'b1;
            end
          end
        end
        END: begin
          if (k_enter) begin
            state <= MENU;
            flags <= flags_of(MENU);
          end
        end
`ifdef GAME_PAUSE_EN
        PAUSE: begin
          if (k_enter) begin
            state <= MENU;
            flags <= flags_of(MENU);
          end else if (k_p) begin
            state <= PLAY;
            flags <= flags_of(PLAY);
          end
        end
`endif
        default: begin
          state <= MENU;
          flags <= flags_of(MENU);
        end
      endcase
    end
  end

  assign bus.menu_screen = flags.menu;
  assign bus.play_active = flags.play;
  assign bus.H_STATE     = flags.hit;
  assign bus.E_STATE     = flags.fin;
  assign bus.pokemon     = pkmn;
  assign bus.pokeball    = ball;
  assign bus.lives       = lives_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl (HIT_FRAMES = 4).
// Covers menu selection, scoring, lives, hit timing and reset.
module tb_game_screen_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  game_screen_ctrl_if gif ();

  game_screen_ctrl #(
    .HIT_FRAMES  (4),
    .START_LIVES (3)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (gif)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(logic [7:0] k);
    gif.keycode = k;
    step();
    gif.keycode = 8'h00;
    step();
  endtask

  task automatic goals(int n);
    for (int i = 0; i < n; i++) begin
      gif.goal_reached = 1'b1;
      step();
      gif.goal_reached = 1'b0;
      step();
    end
  endtask

  task automatic hit_pulse();
    gif.hit = 1'b1;
    step();
    gif.hit = 1'b0;
    step();
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      gif.VGA_VS = 1'b0;
      step();
      gif.VGA_VS = 1'b1;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    gif.VGA_VS = 1'b1;
    gif.keycode = 8'h00;
    gif.hit = 1'b0;
    gif.goal_reached = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_menu", gif.menu_screen, 1);
    check("rst_play", gif.play_active, 0);
    check("rst_hflag", gif.H_STATE, 0);
    check("rst_eflag", gif.E_STATE, 0);
    check("rst_pkmn", gif.pokemon, 1);
    check("rst_ball", gif.pokeball, 4'b0001);
    check("rst_lives", gif.lives, 3);
    check("rst_tens", gif.score_tens, 0);
    check("rst_ones", gif.score_ones, 0);

    press(KEY_LEFT);
    check("left_wrap", gif.pokemon, 3);
    press(KEY_DOWN);
    check("down_once", gif.pokeball, 4'b0010);
    press(KEY_DOWN);
    press(KEY_DOWN);
    press(KEY_DOWN);
    check("down_wrap", gif.pokeball, 4'b0001);
    press(KEY_UP);
    check("up_wrap", gif.pokeball, 4'b1000);
    press(KEY_DOWN);
    gif.keycode = KEY_RIGHT;
    for (int i = 0; i < 10; i++) step();
    gif.keycode = 8'h00;
    step();
    check("right_held", gif.pokemon, 1);

    press(KEY_ENTER);
    check("enter_play", gif.play_active, 1);
    check("enter_menu", gif.menu_screen, 0);
    press(KEY_RIGHT);
    check("play_frozen", gif.pokemon, 1);

    goals(12);
    check("g12_tens", gif.score_tens, 1);
    check("g12_ones", gif.score_ones, 2);

    hit_pulse();
    check("hit_flag", gif.H_STATE, 1);
    check("hit_lives", gif.lives, 2);
    check("hit_noplay", gif.play_active, 0);
    hit_pulse();
    goals(1);
    check("hit_ign_l", gif.lives, 2);
    check("hit_ign_s", gif.score_ones, 2);
    frames(3);
    check("hit_hold", gif.H_STATE, 1);
    frames(1);
    check("hit_done_h", gif.H_STATE, 0);
    check("hit_done_p", gif.play_active, 1);

    gif.hit = 1'b1;
    gif.goal_reached = 1'b1;
    step();
    gif.hit = 1'b0;
    gif.goal_reached = 1'b0;
    step();
    check("both_lives", gif.lives, 1);
    check("both_ones", gif.score_ones, 2);
    check("both_tens", gif.score_tens, 1);
    frames(4);
    check("back_play", gif.play_active, 1);

    hit_pulse();
    check("end_flag", gif.E_STATE, 1);
    check("end_lives", gif.lives, 0);
    check("end_hflag", gif.H_STATE, 0);
    press(KEY_ENTER);
    check("end_menu", gif.menu_screen, 1);
    check("end_score", gif.score_ones, 2);
    check("end_pkmn", gif.pokemon, 1);
    check("end_ball", gif.pokeball, 4'b0001);
    press(KEY_ENTER);
    check("new_ones", gif.score_ones, 0);
    check("new_tens", gif.score_tens, 0);
    check("new_lives", gif.lives, 3);

    goals(102);
    check("sat_tens", gif.score_tens, 9);
    check("sat_ones", gif.score_ones, 9);

    hit_pulse();
    frames(2);
    check("pre_rst_h", gif.H_STATE, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_menu", gif.menu_screen, 1);
    check("mid_hflag", gif.H_STATE, 0);
    check("mid_lives", gif.lives, 3);
    check("mid_tens", gif.score_tens, 0);
    check("mid_ball", gif.pokeball, 4'b0001);
    step();

    press(KEY_ENTER);
    press(KEY_P);
`ifdef GAME_PAUSE_EN
    check("pause_play", gif.play_active, 0);
    check("pause_menu", gif.menu_screen, 0);
    hit_pulse();
    check("pause_lives", gif.lives, 3);
    check("pause_hflag", gif.H_STATE, 0);
    press(KEY_P);
    check("resume", gif.play_active, 1);
`else
    check("p_ignored", gif.play_active, 1);
    hit_pulse();
    check("p_hit", gif.lives, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
